interrupt_sequencer: RTL and testbench

Sequential front end and owner of the CPU interrupt status/control register (0x09). Sits between the raw power/reset button lines, the watchdog, the LPC/register-write path and the CPU interrupt pin. Responsibilities:
- Synchronises, debounces and edge-detects the button lines.
- Latches sticky status bits with software write-1-to-clear.
- Drives the open-drain active-low CPU interrupt through a small FSM. The FSM guarantees a minimum assertion width and a minimum release gap, so edge-sensitive CPU inputs never miss a re-trigger.

---
 rtl/interrupt_pkg.sv | 23 ++
 rtl/button_debounce.sv | 53 +++++
 rtl/interrupt_sequencer.sv | 146 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared state encoding, register bit positions and reset value for the
// CPU interrupt status/control register (0x09).
package interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } intStateT;

  localparam int WDT_BIT = 6;
  localparam int RST_BIT = 5;
  localparam int PWR_BIT = 4;
  localparam int ATX_BIT = 3;

  localparam logic [7:0] INT_REG_RESET = 8'h08;

  function automatic logic [7:0] packIntReg(input logic [6:4] status, input logic atx,
                                            input logic [2:0] enable);
    return {1'b0, status, atx, enable};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability filter for one active-low button line.
// With INT_DEBOUNCE_EN undefined the filter is dropped and Level is the synchroniser output.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnN,
  output logic Level
);

  logic syncA;
  logic syncB;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
    end else begin
      syncA <= BtnN;
      syncB <= syncA;
    end
  end

`ifdef INT_DEBOUNCE_EN
  localparam logic [15:0] HOLD_RELOAD = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] holdCnt;
  logic        stableLevel;

  // Down-counter runs only while the synchronised level disagrees; any match reloads it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stableLevel <= 1'b1;
      holdCnt     <= HOLD_RELOAD;
    end else if (syncB == stableLevel) begin
      holdCnt <= HOLD_RELOAD;
    end else if (holdCnt == 16'd0) begin
      stableLevel <= syncB;
      holdCnt     <= HOLD_RELOAD;
    end else begin
      holdCnt <= holdCnt - 16'd1;
    end
  end

  assign Level = stableLevel;
`else
  localparam int unusedDebounceCycles = DEBOUNCE_CYCLES;

  assign Level = syncB;
`endif

endmodule

// File: rtl/interrupt_sequencer.sv
// Button/watchdog event capture, register 0x09 and the open-drain CPU interrupt pulse shaper.
// Build option INT_DEBOUNCE_EN enables the button debounce filter (see button_debounce).
import interrupt_pkg::*;

module interrupt_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_ASSERT      = 4,
  parameter int MIN_GAP         = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PwrBtnN,
  input  logic       RstBtnN,
  input  logic       WatchDogIREQ,
  input  logic       WrIntReg,
  input  logic [7:0] DataIntReg,
  output logic [7:0] IntRegRd,
  output logic       InterruptD,
  output logic       IrqActive
);

  localparam logic [15:0] ASSERT_LOAD = 16'(MIN_ASSERT - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(MIN_GAP - 1);

  logic       pwrLevel;
  logic       rstLevel;
  logic       pwrLevelQ;
  logic       rstLevelQ;
  logic       wdQ;
  logic       wdPrev;
  logic       pwrEvent;
  logic       rstEvent;
  logic [6:4] status;
  logic [6:4] statusSet;
  logic [6:4] statusClr;
  logic [2:0] enable;
  logic       atx;
  logic       pending;
  intStateT   state;
  logic [15:0] phaseCnt;
  logic       driveLow;
  logic       unusedDataBit;

  assign unusedDataBit = DataIntReg[7];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uPwrDebounce (
    .Clk   (Clk),
    .Reset (Reset),
    .BtnN  (PwrBtnN),
    .Level (pwrLevel)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRstDebounce (
    .Clk   (Clk),
    .Reset (Reset),
    .BtnN  (RstBtnN),
    .Level (rstLevel)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pwrLevelQ <= 1'b1;
      rstLevelQ <= 1'b1;
      wdQ       <= 1'b0;
      wdPrev    <= 1'b0;
    end else begin
      pwrLevelQ <= pwrLevel;
      rstLevelQ <= rstLevel;
      wdQ       <= WatchDogIREQ;
      wdPrev    <= wdQ;
    end
  end

  // ATX boards report on release, legacy boards on press.
  assign pwrEvent = atx ? (pwrLevel & ~pwrLevelQ) : (~pwrLevel & pwrLevelQ);
  assign rstEvent = atx ? (rstLevel & ~rstLevelQ) : (~rstLevel & rstLevelQ);

  always_comb begin
    statusSet          = 3'b000;
    statusSet[WDT_BIT] = wdQ & ~wdPrev;
    statusSet[RST_BIT] = rstEvent;
    statusSet[PWR_BIT] = pwrEvent;
    statusClr          = WrIntReg ? DataIntReg[6:4] : 3'b000;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      status <= 3'b000;
      enable <= 3'b000;
      atx    <= INT_REG_RESET[ATX_BIT];
    end else begin
      status <= (status & ~statusClr) | statusSet;
      if (WrIntReg) begin
        enable <= DataIntReg[2:0];
        atx    <= DataIntReg[ATX_BIT];
      end
    end
  end

  assign IntRegRd = packIntReg(status, atx, enable);
  assign pending  = |(status & enable);

  // ASSERT holds until both the minimum width has elapsed and nothing is pending.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      phaseCnt <= 16'd0;
      driveLow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            state    <= ASSERT;
            phaseCnt <= ASSERT_LOAD;
            driveLow <= 1'b1;
          end
        end
        ASSERT: begin
          if (phaseCnt != 16'd0) begin
            phaseCnt <= phaseCnt - 16'd1;
          end else if (!pending) begin
            state    <= GAP;
            phaseCnt <= GAP_LOAD;
            driveLow <= 1'b0;
          end
        end
        GAP: begin
          if (phaseCnt != 16'd0) begin
            phaseCnt <= phaseCnt - 16'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          phaseCnt <= 16'd0;
          driveLow <= 1'b0;
        end
      endcase
    end
  end

  assign IrqActive  = driveLow;
  assign InterruptD = driveLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; the open-drain line is pulled up so release reads 1.
// Expected button latency follows the INT_DEBOUNCE_EN build option.
module tb_interrupt_sequencer;

`ifdef INT_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       PwrBtnN;
  logic       RstBtnN;
  logic       WatchDogIREQ;
  logic       WrIntReg;
  logic [7:0] DataIntReg;
  logic [7:0] IntRegRd;
  wire        intD;
  logic       IrqActive;

  int total = 0;
  int bad   = 0;

  pullup (intD);

  interrupt_sequencer #(.DEBOUNCE_CYCLES(16), .MIN_ASSERT(4), .MIN_GAP(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PwrBtnN      (PwrBtnN),
    .RstBtnN      (RstBtnN),
    .WatchDogIREQ (WatchDogIREQ),
    .WrIntReg     (WrIntReg),
    .DataIntReg   (DataIntReg),
    .IntRegRd     (IntRegRd),
    .InterruptD   (intD),
    .IrqActive    (IrqActive)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic writeReg(input logic [7:0] d);
    WrIntReg   = 1'b1;
    DataIntReg = d;
    tick();
    WrIntReg   = 1'b0;
    DataIntReg = 8'h00;
  endtask

  task automatic settle(input logic [7:0] cfg);
    repeat (40) tick();
    writeReg(cfg | 8'h70);
    repeat (10) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    total++; if (IntRegRd !== 8'h08) begin bad++; $display("FAIL reset_reg got=%h want=08", IntRegRd); end
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL reset_intd got=%b want=1", intD); end
    total++; if (IrqActive !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", IrqActive); end
    Reset = 1'b0;
    repeat (LAT + 3) tick();
    total++; if (IntRegRd !== 8'h08) begin bad++; $display("FAIL reset_exit_reg got=%h want=08", IntRegRd); end
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL reset_exit_intd got=%b want=1", intD); end
  endtask

  task automatic test_pwr_release();
    writeReg(8'h09);
    total++; if (IntRegRd !== 8'h09) begin bad++; $display("FAIL pwr_cfg got=%h want=09", IntRegRd); end
    PwrBtnN = 1'b0;
    repeat (20) tick();
    PwrBtnN = 1'b1;
    total++; if (IntRegRd !== 8'h09) begin bad++; $display("FAIL pwr_press_ignored got=%h want=09", IntRegRd); end
    repeat (LAT - 1) tick();
    total++; if (IntRegRd !== 8'h09) begin bad++; $display("FAIL pwr_early got=%h want=09", IntRegRd); end
    tick();
    total++; if (IntRegRd !== 8'h19) begin bad++; $display("FAIL pwr_status got=%h want=19", IntRegRd); end
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL pwr_intd_pre got=%b want=1", intD); end
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL pwr_intd_low got=%b want=0", intD); end
    total++; if (IrqActive !== 1'b1) begin bad++; $display("FAIL pwr_active got=%b want=1", IrqActive); end
    writeReg(8'h19);
    total++; if (IntRegRd !== 8'h09) begin bad++; $display("FAIL pwr_clear got=%h want=09", IntRegRd); end
    for (int i = 0; i < 3; i++) begin
      total++; if (intD !== 1'b0) begin bad++; $display("FAIL pwr_width cyc=%0d got=%b want=0", i + 1, intD); end
      if (i < 2) tick();
    end
    tick();
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL pwr_release_intd got=%b want=1", intD); end
    total++; if (IrqActive !== 1'b0) begin bad++; $display("FAIL pwr_release_active got=%b want=0", IrqActive); end
    settle(8'h09);
  endtask

`ifdef INT_DEBOUNCE_EN
  task automatic test_bounce();
    writeReg(8'h01);
    for (int seg = 0; seg < 8; seg++) begin
      PwrBtnN = seg[0];
      repeat (5) tick();
    end
    repeat (LAT) tick();
    total++; if (IntRegRd !== 8'h01) begin bad++; $display("FAIL bounce_ignored got=%h want=01", IntRegRd); end
    PwrBtnN = 1'b0;
    repeat (15) tick();
    PwrBtnN = 1'b1;
    repeat (LAT + 2) tick();
    total++; if (IntRegRd !== 8'h01) begin bad++; $display("FAIL bounce_short15 got=%h want=01", IntRegRd); end
    PwrBtnN = 1'b0;
    repeat (16) tick();
    PwrBtnN = 1'b1;
    repeat (2) tick();
    total++; if (IntRegRd !== 8'h01) begin bad++; $display("FAIL bounce_hold16_early got=%h want=01", IntRegRd); end
    tick();
    total++; if (IntRegRd !== 8'h11) begin bad++; $display("FAIL bounce_hold16 got=%h want=11", IntRegRd); end
    settle(8'h01);
  endtask
`endif

  task automatic test_wdt_set_wins();
    writeReg(8'h0C);
    WatchDogIREQ = 1'b1;
    tick();
    WrIntReg   = 1'b1;
    DataIntReg = 8'h4C;
    tick();
    WrIntReg   = 1'b0;
    DataIntReg = 8'h00;
    total++; if (IntRegRd !== 8'h4C) begin bad++; $display("FAIL wdt_set_wins got=%h want=4c", IntRegRd); end
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL wdt_intd_pre got=%b want=1", intD); end
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL wdt_intd_low got=%b want=0", intD); end
    writeReg(8'h44);
    total++; if (IntRegRd !== 8'h04) begin bad++; $display("FAIL wdt_clear got=%h want=04", IntRegRd); end
    for (int i = 0; i < 3; i++) begin
      total++; if (intD !== 1'b0) begin bad++; $display("FAIL wdt_width cyc=%0d got=%b want=0", i + 1, intD); end
      if (i < 2) tick();
    end
    tick();
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL wdt_release got=%b want=1", intD); end
    repeat (10) tick();
    total++; if (IntRegRd !== 8'h04) begin bad++; $display("FAIL wdt_level_no_retrig got=%h want=04", IntRegRd); end
    WatchDogIREQ = 1'b0;
    settle(8'h04);
  endtask

  task automatic test_gap_retrigger();
    writeReg(8'h0E);
    RstBtnN = 1'b0;
    repeat (20) tick();
    RstBtnN = 1'b1;
    repeat (LAT) tick();
    total++; if (IntRegRd !== 8'h2E) begin bad++; $display("FAIL gap_rst_status got=%h want=2e", IntRegRd); end
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL gap_assert got=%b want=0", intD); end
    writeReg(8'h2E);
    total++; if (IntRegRd !== 8'h0E) begin bad++; $display("FAIL gap_clear got=%h want=0e", IntRegRd); end
    tick();
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL gap_width4 got=%b want=0", intD); end
    WatchDogIREQ = 1'b1;
    tick();
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL gap_cyc1 got=%b want=1", intD); end
    tick();
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL gap_cyc2 got=%b want=1", intD); end
    total++; if (IntRegRd !== 8'h4E) begin bad++; $display("FAIL gap_wdt_status got=%h want=4e", IntRegRd); end
    tick();
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL gap_idle got=%b want=1", intD); end
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL gap_reassert got=%b want=0", intD); end
    WatchDogIREQ = 1'b0;
    settle(8'h0E);
  endtask

  task automatic test_short_pulse();
    writeReg(8'h02);
    RstBtnN = 1'b0;
    tick();
    RstBtnN = 1'b1;
`ifdef INT_DEBOUNCE_EN
    repeat (LAT + 2) tick();
    total++; if (IntRegRd !== 8'h02) begin bad++; $display("FAIL short_filtered got=%h want=02", IntRegRd); end
`else
    tick();
    total++; if (IntRegRd !== 8'h02) begin bad++; $display("FAIL short_early got=%h want=02", IntRegRd); end
    tick();
    total++; if (IntRegRd !== 8'h22) begin bad++; $display("FAIL short_status got=%h want=22", IntRegRd); end
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL short_intd got=%b want=0", intD); end
`endif
    settle(8'h02);
  endtask

  task automatic test_reset_mid();
    writeReg(8'h0F);
    PwrBtnN = 1'b0;
    RstBtnN = 1'b0;
    repeat (20) tick();
    PwrBtnN = 1'b1;
    RstBtnN = 1'b1;
    repeat (LAT - 2) tick();
    WatchDogIREQ = 1'b1;
    repeat (2) tick();
    total++; if (IntRegRd !== 8'h7F) begin bad++; $display("FAIL mid_all_status got=%h want=7f", IntRegRd); end
    tick();
    total++; if (intD !== 1'b0) begin bad++; $display("FAIL mid_assert got=%b want=0", intD); end
    Reset        = 1'b1;
    WatchDogIREQ = 1'b0;
    tick();
    total++; if (IntRegRd !== 8'h08) begin bad++; $display("FAIL mid_reset_reg got=%h want=08", IntRegRd); end
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL mid_reset_intd got=%b want=1", intD); end
    total++; if (IrqActive !== 1'b0) begin bad++; $display("FAIL mid_reset_active got=%b want=0", IrqActive); end
    Reset = 1'b0;
    repeat (LAT + 5) tick();
    total++; if (IntRegRd !== 8'h08) begin bad++; $display("FAIL mid_exit_reg got=%h want=08", IntRegRd); end
    total++; if (intD !== 1'b1) begin bad++; $display("FAIL mid_exit_intd got=%b want=1", intD); end
  endtask

  initial begin
    Reset        = 1'b1;
    PwrBtnN      = 1'b1;
    RstBtnN      = 1'b1;
    WatchDogIREQ = 1'b0;
    WrIntReg     = 1'b0;
    DataIntReg   = 8'h00;
    test_reset();
    test_pwr_release();
`ifdef INT_DEBOUNCE_EN
    test_bounce();
`endif
    test_wdt_set_wins();
    test_gap_retrigger();
    test_short_pulse();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
